// File: rtl/ravenoc_pkg.sv
// Shared NoC definitions: flit framing, virtual channel sizing and the
// injection arbiter state encoding.
package ravenoc_pkg;

    localparam int FLIT_WIDTH    = 34;
    localparam int FLIT_TP_WIDTH = 2;
    localparam int N_VIRT_CHN    = 2;
    localparam int VC_WIDTH      = $clog2(N_VIRT_CHN);

    // Flit type carried in the top FLIT_TP_WIDTH bits of every flit
    typedef enum logic [FLIT_TP_WIDTH-1:0] {
        HEAD_FLIT      = 2'd0,
        BODY_FLIT      = 2'd1,
        TAIL_FLIT      = 2'd2,
        HEAD_TAIL_FLIT = 2'd3
    } flit_type_t;

    // Injection arbiter: nothing held, winner held awaiting ready, packet owns link
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_PEND = 2'd1,
        ARB_LOCK = 2'd2
    } arb_st_t;

endpackage

// File: rtl/vc_age_counter.sv
// Per-VC starvation age counter: counts cycles a head flit waits, saturates
// at STARVE_MAX, clears when that head is accepted, and pulses on reaching
// the saturation value.
module vc_age_counter #(
    parameter int STARVE_MAX = 16
) (
    input  logic clk_noc,
    input  logic arst_noc,
    input  logic start,
    input  logic clear,
    output logic saturated,
    output logic reach
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] PRE_CNT = CNT_W'(STARVE_MAX - 1);

    logic [CNT_W-1:0] count_q;

    // Age register: clear on accept, count while waiting, hold at saturation
    always_ff @(posedge clk_noc) begin
        if (arst_noc) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (start && (count_q != MAX_CNT)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign saturated = (count_q == MAX_CNT);

    // The pulse marks the cycle whose clock edge moves the count onto STARVE_MAX
    assign reach = !arst_noc && start && !clear && (count_q == PRE_CNT);

endmodule

// File: rtl/vc_inject_arbiter.sv
// Injection-link arbiter for the NI: fixed priority (highest VC wins) with
// age-based promotion of starved VCs, and wormhole locking so a started
// packet owns the link until its tail. Datapath is purely combinational.
// N_VC must be at least 2.
module vc_inject_arbiter
    import ravenoc_pkg::*;
#(
    parameter int N_VC       = N_VIRT_CHN,
    parameter int FLIT_W     = FLIT_WIDTH,
    parameter int TP_W       = FLIT_TP_WIDTH,
    parameter int STARVE_MAX = 16
) (
    input  logic                     clk_noc,
    input  logic                     arst_noc,
    input  logic [N_VC-1:0]          vc_valid_i,
    input  logic [N_VC*FLIT_W-1:0]   vc_flit_i,
    output logic [N_VC-1:0]          vc_ready_o,
    output logic                     out_valid_o,
    output logic [FLIT_W-1:0]        out_flit_o,
    output logic [$clog2(N_VC)-1:0]  out_vc_o,
    input  logic                     out_ready_i,
    output logic                     lock_o,
    output logic [N_VC-1:0]          starve_evt_o
);

    localparam int SEL_W = $clog2(N_VC);

    logic [FLIT_W-1:0] flit_arr [N_VC];
    logic [TP_W-1:0]   tp_arr   [N_VC];
    logic [N_VC-1:0]   head_req;
    logic [N_VC-1:0]   saturated;
    logic [N_VC-1:0]   head_hs;

    arb_st_t           state_q;
    arb_st_t           state_d;
    logic [SEL_W-1:0]  held_q;
    logic [SEL_W-1:0]  held_d;
    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  winner;
    logic              found;
    logic              hs;
    logic [TP_W-1:0]   sel_tp;

    for (genvar i = 0; i < N_VC; i++) begin : g_vc
        assign flit_arr[i] = vc_flit_i[i*FLIT_W +: FLIT_W];
        assign tp_arr[i]   = flit_arr[i][FLIT_W-1 -: TP_W];
        assign head_req[i] = vc_valid_i[i] &&
                             ((tp_arr[i] == TP_W'(HEAD_FLIT)) ||
                              (tp_arr[i] == TP_W'(HEAD_TAIL_FLIT)));
        assign head_hs[i]  = hs && (sel == SEL_W'(i)) && head_req[i];

        vc_age_counter #(
            .STARVE_MAX (STARVE_MAX)
        ) u_age (
            .clk_noc   (clk_noc),
            .arst_noc  (arst_noc),
            .start     (head_req[i]),
            .clear     (head_hs[i]),
            .saturated (saturated[i]),
            .reach     (starve_evt_o[i])
        );
    end

    // State and held-VC registers; reset abandons any packet in flight
    always_ff @(posedge clk_noc) begin
        if (arst_noc) begin
            state_q <= ARB_IDLE;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    // Winner selection, output qualification, grant and next-state decode
    always_comb begin
        winner      = '0;
        found       = 1'b0;
        state_d     = state_q;
        held_d      = held_q;
        sel         = held_q;
        out_valid_o = 1'b0;
        vc_ready_o  = '0;

        for (int i = 0; i < N_VC; i++) begin
            if (head_req[i]) begin
                winner = SEL_W'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N_VC; i++) begin
            if (head_req[i] && saturated[i]) begin
                winner = SEL_W'(i);
            end
        end

        case (state_q)
            ARB_IDLE: begin
                sel         = winner;
                out_valid_o = found;
            end
            ARB_PEND, ARB_LOCK: begin
                out_valid_o = vc_valid_i[held_q];
            end
            default: begin
                out_valid_o = 1'b0;
            end
        endcase

        if (arst_noc) begin
            out_valid_o = 1'b0;
        end

        hs     = out_valid_o && out_ready_i;
        sel_tp = tp_arr[sel];

        if (hs) begin
            vc_ready_o[sel] = 1'b1;
        end

        case (state_q)
            ARB_IDLE, ARB_PEND: begin
                held_d = sel;
                if (hs) begin
                    state_d = (sel_tp == TP_W'(HEAD_FLIT)) ? ARB_LOCK : ARB_IDLE;
                end else if (out_valid_o) begin
                    state_d = ARB_PEND;
                end
            end
            ARB_LOCK: begin
                if (hs && (sel_tp == TP_W'(TAIL_FLIT))) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign out_flit_o = flit_arr[sel];
    assign out_vc_o   = sel;
    assign lock_o     = (state_q == ARB_LOCK) && !arst_noc;

endmodule
